// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
//   Tile-stepping player movement controller. A keypress facing the current
//   direction walks the player one full tile, one pixel every SPEED frames;
//   a keypress in another direction turns the player in place for
//   TURN_FRAMES frames. All state changes happen on frame ticks derived from
//   the (asynchronous) VS input.
//
// Ports
//   Clk               in   system clock
//   Reset             in   synchronous, active-high reset
//   VS                in   vertical sync, asynchronous to Clk
//   keycode[7:0]      in   USB HID keycode (0x1A up, 0x07 right, 0x16 down,
//                          0x04 left, anything else = no key)
//   Character_Moving  out  high while a tile step is in progress
//   Direction[1:0]    out  facing: 0 up, 1 right, 2 down, 3 left
//   Pos_X[9:0]        out  world X position in pixels
//   Pos_Y[9:0]        out  world Y position in pixels
//   Step_Done         out  one-cycle pulse when a tile step completes
// -----------------------------------------------------------------------------
module player_motion_ctrl #(
  parameter int TILE        = 16,
  parameter int MAP_W       = 640,
  parameter int MAP_H       = 480,
  parameter int START_X     = 320,
  parameter int START_Y     = 352,
  parameter int SPEED       = 1,
  parameter int TURN_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       VS,
  input  logic [7:0] keycode,
  output logic       Character_Moving,
  output logic [1:0] Direction,
  output logic [9:0] Pos_X,
  output logic [9:0] Pos_Y,
  output logic       Step_Done
);

  localparam int PW = $clog2(TILE + 1);
  localparam int DW = $clog2(SPEED + 1);
  localparam int TW = $clog2(TURN_FRAMES + 2);

  localparam logic [9:0]    X_MAX     = 10'(MAP_W - TILE);
  localparam logic [9:0]    Y_MAX     = 10'(MAP_H - TILE);
  localparam logic [9:0]    X_START   = 10'(START_X);
  localparam logic [9:0]    Y_START   = 10'(START_Y);
  localparam logic [PW-1:0] PIX_LAST  = PW'(TILE - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SPEED - 1);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURN_FRAMES);

  typedef enum logic [1:0] {IDLE, TURN, WALK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [9:0]    px_q, px_d, py_q, py_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          done_q, done_d;

  // VS synchronizer and rising-edge detector.
  logic vs_meta, vs_sync, vs_prev;
  logic frame_tick;

  // NOTE: the whole block uses a synchronous reset, so every flop (including
  // the synchronizer) clears only on a Clk edge with Reset high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;

  // Key decode.
  logic       key_valid;
  logic [1:0] key_dir;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    key_valid = 1'b1;
    key_dir   = 2'd0;
    case (keycode)
      8'h1A:   key_dir = 2'd0;
      8'h07:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h04:   key_dir = 2'd3;
      default: key_valid = 1'b0;
    endcase
  end

  function automatic logic is_blocked(input logic [1:0] d,
                                      input logic [9:0] x,
                                      input logic [9:0] y);
    logic b;
    case (d)
      2'd0:    b = (y == 10'd0);
      2'd1:    b = (x >= X_MAX);
      2'd2:    b = (y >= Y_MAX);
      default: b = (x == 10'd0);
    endcase
    return b;
  endfunction

  // Position after a one-pixel move in the facing direction.
  logic [9:0] mx, my;
  always_comb begin
    mx = px_q;
    my = py_q;
    case (dir_q)
      2'd0:    my = py_q - 10'd1;
      2'd1:    mx = px_q + 10'd1;
      2'd2:    my = py_q + 10'd1;
      default: mx = px_q - 10'd1;
    endcase
  end

  // Next-state logic. Nothing changes except on a frame tick.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    px_d    = px_q;
    py_d    = py_q;
    pix_d   = pix_q;
    div_d   = div_q;
    turn_d  = turn_q;
    done_d  = 1'b0;

    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (key_valid && key_dir != dir_q) begin
            dir_d   = key_dir;
            turn_d  = TURN_INIT;
            state_d = TURN;
          end else if (key_valid && !is_blocked(dir_q, px_q, py_q)) begin
            pix_d   = '0;
            div_d   = '0;
            state_d = WALK;
          end
        end

        TURN: begin
          // A zero count (TURN_FRAMES == 0) leaves on the first tick too.
          if (turn_q == '0 || turn_q == TW'(1)) begin
            turn_d  = '0;
            state_d = IDLE;
          end else begin
            turn_d = turn_q - TW'(1);
          end
        end

        WALK: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            px_d  = mx;
            py_d  = my;
            if (pix_q == PIX_LAST) begin
              // Tile boundary: the key is sampled again here, and the block
              // test uses the position we are just arriving at.
              pix_d  = '0;
              done_d = 1'b1;
              if (!(key_valid && key_dir == dir_q && !is_blocked(dir_q, mx, my)))
                state_d = IDLE;
            end else begin
              pix_d = pix_q + PW'(1);
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed for this cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      px_q    <= X_START;
      py_q    <= Y_START;
      pix_q   <= '0;
      div_q   <= '0;
      turn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pix_q   <= pix_d;
      div_q   <= div_d;
      turn_q  <= turn_d;
      done_q  <= done_d;
    end
  end

  assign Character_Moving = (state_q == WALK);
  assign Direction        = dir_q;
  assign Pos_X            = px_q;
  assign Pos_Y            = py_q;
  assign Step_Done        = done_q;

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 SHALL have parameter TILE, 16, pixels per tile step (power of two).
REQ-002 SHALL have parameter MAP_W, 640, world width in pixels.
REQ-003 SHALL have parameter MAP_H, 480, world height in pixels.
REQ-004 SHALL have parameters START_X, 320 and START_Y, 352: tile-aligned reset position.
REQ-005 SHALL have parameter SPEED, 1, frame ticks per 1-pixel move (>=1).
REQ-006 SHALL have parameter TURN_FRAMES, 4, frames spent turning in place.
REQ-007 Clk  in  1  system clock; Reset, synchronous, active-high; clock Clk.
REQ-008 Reset  in  1  synchronous active-high reset.
REQ-009 VS  in  1  vertical sync, asynchronous to Clk.
REQ-010 keycode  in  8  USB HID keycode, 0x00 = no key.
REQ-011 Character_Moving  out  1  high while a tile step is in progress.
REQ-012 Direction  out  2  facing: 0 up, 1 right, 2 down, 3 left.
REQ-013 Pos_X, Pos_Y  out  10 each  player world position in pixels.
REQ-014 Step_Done  out  1  one-cycle pulse when a tile step completes.

Function
REQ-015 VS SHALL pass a 2-flop synchronizer plus edge detector; frame_tick SHALL be high exactly one Clk per VS rising edge, within 3 Clk of the edge.
REQ-016 Key decode SHALL be 0x1A->0, 0x07->1, 0x16->2, 0x04->3; any other value SHALL be "no key".
REQ-017 FSM states SHALL be IDLE, TURN, WALK; all transitions and position updates SHALL occur only on frame_tick cycles.
REQ-018 Blocked test: dir 0 blocked if Pos_Y==0; 1 if Pos_X>=MAP_W-TILE; 2 if Pos_Y>=MAP_H-TILE; 3 if Pos_X==0.
REQ-019 IDLE, valid key != Direction: Direction<=key, turn counter<=TURN_FRAMES, go TURN.
REQ-020 IDLE, valid key == Direction and not blocked: go WALK, pixel counter<=0, frame divider<=0.
REQ-021 IDLE, key == Direction but blocked, or no key: remain IDLE, position unchanged.
REQ-022 TURN: decrement counter per frame_tick; go IDLE when it reaches 0; key input ignored; TURN_FRAMES==0 SHALL return to IDLE on the next tick.
REQ-023 WALK: frame divider counts 0..SPEED-1; at SPEED-1 position moves 1 pixel in Direction and pixel counter increments.
REQ-024 Key changes and releases during WALK SHALL be ignored until the tile boundary.
REQ-025 When the pixel counter reaches TILE, Step_Done SHALL pulse that cycle; if key == Direction and not blocked, stay WALK with counter<=0, else go IDLE.
REQ-026 At the boundary a different valid key SHALL go IDLE (the turn is handled from IDLE).
REQ-027 Character_Moving SHALL be 1 exactly in WALK; Pos_X/Pos_Y SHALL be tile-aligned whenever state is IDLE or TURN.
REQ-028 Position arithmetic SHALL be 10-bit unsigned and SHALL never leave [0, MAP_W-TILE] x [0, MAP_H-TILE].

Reset
REQ-029 Reset SHALL force state IDLE, Direction=0, Pos_X=START_X, Pos_Y=START_Y, Character_Moving=0, Step_Done=0, all counters 0, synchronizer flops 0.
REQ-030 Reset mid-WALK or mid-TURN SHALL abandon the step immediately with no Step_Done pulse.
REQ-031 Reset SHALL take priority over a coincident frame_tick.

Verification
REQ-032 Reset, keycode=0x1A held 16 ticks -> Character_Moving=1 from tick 1, Pos_Y 352->336, Step_Done on tick 16, Direction=0.
REQ-033 Idle facing up, keycode=0x07 one tick then 0x00 -> Direction=1, TURN 4 ticks, Pos unchanged, Character_Moving=0 throughout.
REQ-034 Mid-WALK up, keycode->0x00 at pixel 5 -> step continues to pixel 16, Pos_Y=336, then IDLE.
REQ-035 Pos_Y=0, facing up, keycode=0x1A -> stays IDLE, Pos_Y=0, no Step_Done.
REQ-036 SPEED=2, up held -> 32 ticks per tile; Step_Done on tick 32; continuous walk keeps Character_Moving=1 across the boundary.
REQ-037 Reset asserted at pixel 8 of WALK -> next cycle Pos=(320,352), IDLE, Step_Done never pulses.
